// File: rtl/syn_fifo_pkg.sv
// Shared definitions for the single-clock FIFO: depth derivation, read-mode
// constants and the parameter-legality check used at elaboration.
package syn_fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic bit fifo_params_legal(input int addr_width, input int ae_level,
                                             input int af_level, input int mode);
        return (addr_width >= 1) && (ae_level >= 0) && (ae_level < af_level) &&
               (af_level <= fifo_depth(addr_width)) &&
               ((mode == FIFO_STD) || (mode == FIFO_FWFT));
    endfunction

endpackage

// File: rtl/syn_fifo_ram.sv
// Simple dual-port RAM: one clock, one write port, one registered read port.
// Neither the array nor the read register is reset.
module syn_fifo_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/syn_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through read mode, fill
// count, programmable almost flags, error pulses and synchronous flush.
module syn_fifo
    import syn_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fill_cnt,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int               PW      = ADDR_WIDTH + 1;
    localparam int               DEPTH   = fifo_depth(ADDR_WIDTH);
    localparam logic [PW-1:0]    DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0]    AF_C    = PW'(AF_LEVEL);
    localparam logic [PW-1:0]    AE_C    = PW'(AE_LEVEL);
    localparam bit               IS_FWFT = (FWFT == FIFO_FWFT);

    if (!fifo_params_legal(ADDR_WIDTH, AE_LEVEL, AF_LEVEL, FWFT)) begin : g_param_check
        $error("syn_fifo: illegal parameter combination");
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fill_q, fill_d, ram_cnt;
    logic          full_q, full_d, af_q, af_d, empty_q, empty_d, ae_q, ae_d;
    logic          dv_q, dv_d, ovf_q, ovf_d, unf_q, unf_d;
    logic          ovalid_q, ovalid_d, out_init_q, out_init_d;
    logic          wr_acc, rd_acc, ram_rd;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    always_comb begin
        wr_acc  = wr_en & ~full_q & ~clr;
        rd_acc  = rd_en & ~empty_q & ~clr;
        ram_cnt = wr_ptr_q - rd_ptr_q;
        // In FWFT the RAM read refills the output register whenever it is
        // empty or being popped, so the head is always presented.
        if (IS_FWFT) ram_rd = (ram_cnt != '0) & (~ovalid_q | rd_acc) & ~clr;
        else         ram_rd = rd_acc;

        wr_ptr_d = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_acc};
        rd_ptr_d = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, ram_rd};
        unique case ({wr_acc, rd_acc})
            2'b10:   fill_d = fill_q + PW'(1);
            2'b01:   fill_d = fill_q - PW'(1);
            default: fill_d = fill_q;
        endcase
        ovalid_d   = IS_FWFT & (ram_rd | (ovalid_q & ~rd_acc));
        out_init_d = out_init_q | ram_rd;

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
            ovalid_d = 1'b0;
        end

        full_d  = (fill_d == DEPTH_C);
        af_d    = (fill_d >= AF_C);
        ae_d    = (fill_d <= AE_C);
        empty_d = IS_FWFT ? ~ovalid_d : (fill_d == '0);
        dv_d    = IS_FWFT ? ovalid_d : ram_rd;
        ovf_d   = wr_en & full_q & ~clr;
        unf_d   = rd_en & empty_q & ~clr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            full_q     <= 1'b0;
            af_q       <= 1'b0;
            empty_q    <= 1'b1;
            ae_q       <= 1'b1;
            dv_q       <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            ovalid_q   <= 1'b0;
            out_init_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            full_q     <= full_d;
            af_q       <= af_d;
            empty_q    <= empty_d;
            ae_q       <= ae_d;
            dv_q       <= dv_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            ovalid_q   <= ovalid_d;
            out_init_q <= out_init_d;
        end
    end

    syn_fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data (data_in),
        .rd_en   (ram_rd),
        .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data (ram_rd_data)
    );

    // The RAM read register has no reset; mask it until the first read so
    // data_out comes out of reset as zero.
    assign data_out     = out_init_q ? ram_rd_data : '0;
    assign full         = full_q;
    assign almost_full  = af_q;
    assign empty        = empty_q;
    assign almost_empty = ae_q;
    assign data_valid   = dv_q;
    assign fill_cnt     = fill_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_syn_fifo.sv
// Scoreboard bench for syn_fifo: a standard-mode and an FWFT-mode instance,
// DEPTH=8, AF_LEVEL=6, AE_LEVEL=1.
module tb_syn_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic        s_clr = 0, s_wr = 0, s_rd = 0;
    logic [15:0] s_din = '0, s_dout;
    logic        s_full, s_af, s_dv, s_empty, s_ae, s_ovf, s_unf;
    logic [3:0]  s_fill;

    logic        f_clr = 0, f_wr = 0, f_rd = 0;
    logic [15:0] f_din = '0, f_dout;
    logic        f_full, f_af, f_dv, f_empty, f_ae, f_ovf, f_unf;
    logic [3:0]  f_fill;

    syn_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(1)) u_std (
        .clk(clk), .rst(rst), .clr(s_clr), .wr_en(s_wr), .data_in(s_din), .full(s_full),
        .almost_full(s_af), .rd_en(s_rd), .data_out(s_dout), .data_valid(s_dv),
        .empty(s_empty), .almost_empty(s_ae), .fill_cnt(s_fill), .overflow(s_ovf),
        .underflow(s_unf));

    syn_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(1)) u_fwft (
        .clk(clk), .rst(rst), .clr(f_clr), .wr_en(f_wr), .data_in(f_din), .full(f_full),
        .almost_full(f_af), .rd_en(f_rd), .data_out(f_dout), .data_valid(f_dv),
        .empty(f_empty), .almost_empty(f_ae), .fill_cnt(f_fill), .overflow(f_ovf),
        .underflow(f_unf));

    int          total = 0;
    int          bad = 0;
    logic [15:0] sb_s[$];
    logic [15:0] sb_f[$];
    logic [3:0]  m_cnt = '0;
    logic        m_racc, m_ovf, m_unf;
    logic [15:0] m_last = '0;
    logic [15:0] exp_w;

    // Drives one cycle on the standard instance and advances the reference model.
    task automatic drive_s(input logic w, input logic [15:0] d, input logic r, input logic c);
        logic wacc;
        s_wr = w; s_din = d; s_rd = r; s_clr = c;
        if (c) begin
            m_racc = 0; m_ovf = 0; m_unf = 0; m_cnt = '0;
            sb_s.delete();
        end else begin
            m_racc = r && (m_cnt != 0);
            wacc   = w && (m_cnt != 8);
            m_ovf  = w && !wacc;
            m_unf  = r && !m_racc;
            if (wacc) sb_s.push_back(d);
            if (wacc && !m_racc) m_cnt = m_cnt + 4'd1;
            if (!wacc && m_racc) m_cnt = m_cnt - 4'd1;
        end
        @(posedge clk); #1;
        s_wr = 0; s_rd = 0; s_clr = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        total++; if ({s_fill, s_empty, s_ae, s_full, s_af, s_dv, s_ovf, s_unf} !== {4'd0, 7'b1100000}) begin
            bad++; $display("FAIL reset_std_flags got=%b want=%b", {s_fill, s_empty, s_ae, s_full, s_af, s_dv, s_ovf, s_unf}, {4'd0, 7'b1100000});
        end
        total++; if (s_dout !== 16'h0000) begin bad++; $display("FAIL reset_std_dout got=%h want=0000", s_dout); end
        total++; if ({f_fill, f_empty, f_ae, f_full, f_af, f_dv, f_ovf, f_unf} !== {4'd0, 7'b1100000}) begin
            bad++; $display("FAIL reset_fwft_flags got=%b want=%b", {f_fill, f_empty, f_ae, f_full, f_af, f_dv, f_ovf, f_unf}, {4'd0, 7'b1100000});
        end
    endtask

    task automatic test_fill_overflow;
        for (int i = 1; i <= 8; i++) begin
            drive_s(1, 16'(i), 0, 0);
            total++; if (s_fill !== m_cnt) begin bad++; $display("FAIL fill_cnt_wr%0d got=%0d want=%0d", i, s_fill, m_cnt); end
            total++; if (s_af !== (i >= 6)) begin bad++; $display("FAIL almost_full_wr%0d got=%b want=%b", i, s_af, (i >= 6)); end
            total++; if (s_full !== (i == 8)) begin bad++; $display("FAIL full_wr%0d got=%b want=%b", i, s_full, (i == 8)); end
            total++; if (s_ae !== (i <= 1)) begin bad++; $display("FAIL almost_empty_wr%0d got=%b want=%b", i, s_ae, (i <= 1)); end
        end
        drive_s(1, 16'h0009, 0, 0);
        total++; if (s_ovf !== 1'b1) begin bad++; $display("FAIL overflow_pulse got=%b want=1", s_ovf); end
        total++; if (s_fill !== 4'd8) begin bad++; $display("FAIL fill_after_ovf got=%0d want=8", s_fill); end
        drive_s(0, 16'h0000, 0, 0);
        total++; if (s_ovf !== 1'b0) begin bad++; $display("FAIL overflow_one_cycle got=%b want=0", s_ovf); end
    endtask

    task automatic test_drain_underflow;
        for (int i = 1; i <= 9; i++) begin
            drive_s(0, 16'h0000, 1, 0);
            total++; if (s_dv !== m_racc) begin bad++; $display("FAIL drain_dv%0d got=%b want=%b", i, s_dv, m_racc); end
            if (s_dv === 1'b1) begin
                if (sb_s.size() == 0) begin
                    total++; bad++; $display("FAIL drain_sb_empty%0d got=%h want=none", i, s_dout);
                end else begin
                    exp_w = sb_s.pop_front(); m_last = exp_w;
                    total++; if (s_dout !== exp_w) begin bad++; $display("FAIL drain_data%0d got=%h want=%h", i, s_dout, exp_w); end
                end
            end
            total++; if (s_empty !== (i >= 8)) begin bad++; $display("FAIL drain_empty%0d got=%b want=%b", i, s_empty, (i >= 8)); end
            total++; if (s_unf !== m_unf) begin bad++; $display("FAIL drain_underflow%0d got=%b want=%b", i, s_unf, m_unf); end
        end
        total++; if (s_dout !== 16'h0008) begin bad++; $display("FAIL underflow_hold got=%h want=0008", s_dout); end
    endtask

    task automatic test_steady_wrap;
        for (int i = 0; i < 4; i++) drive_s(1, 16'h0010 + 16'(i), 0, 0);
        for (int i = 0; i < 20; i++) begin
            drive_s(1, 16'h0100 + 16'(i), 1, 0);
            total++; if (s_fill !== 4'd4) begin bad++; $display("FAIL wrap_fill%0d got=%0d want=4", i, s_fill); end
            total++; if (s_dv !== 1'b1) begin bad++; $display("FAIL wrap_dv%0d got=%b want=1", i, s_dv); end
            if (s_dv === 1'b1 && sb_s.size() != 0) begin
                exp_w = sb_s.pop_front(); m_last = exp_w;
                total++; if (s_dout !== exp_w) begin bad++; $display("FAIL wrap_data%0d got=%h want=%h", i, s_dout, exp_w); end
            end
        end
    endtask

    task automatic test_full_rdwr;
        for (int i = 0; i < 4; i++) drive_s(1, 16'h0200 + 16'(i), 0, 0);
        total++; if (s_full !== 1'b1) begin bad++; $display("FAIL full_before_rdwr got=%b want=1", s_full); end
        drive_s(1, 16'hBEEF, 1, 0);
        total++; if (s_ovf !== 1'b1) begin bad++; $display("FAIL full_rdwr_ovf got=%b want=1", s_ovf); end
        total++; if (s_fill !== 4'd7) begin bad++; $display("FAIL full_rdwr_fill got=%0d want=7", s_fill); end
        exp_w = sb_s.pop_front(); m_last = exp_w;
        total++; if (s_dout !== exp_w) begin bad++; $display("FAIL full_rdwr_data got=%h want=%h", s_dout, exp_w); end
        for (int i = 0; i < 7; i++) begin
            drive_s(0, 16'h0000, 1, 0);
            if (s_dv === 1'b1 && sb_s.size() != 0) begin
                exp_w = sb_s.pop_front(); m_last = exp_w;
                total++; if (s_dout !== exp_w || s_dout === 16'hBEEF) begin bad++; $display("FAIL full_drain%0d got=%h want=%h", i, s_dout, exp_w); end
            end else begin
                total++; bad++; $display("FAIL full_drain_dv%0d got=%b want=1", i, s_dv);
            end
        end
        total++; if (s_empty !== 1'b1) begin bad++; $display("FAIL full_drain_empty got=%b want=1", s_empty); end
    endtask

    task automatic test_fwft;
        f_wr = 1; f_din = 16'hA5A5;
        @(posedge clk); #1 f_wr = 0;
        total++; if (f_fill !== 4'd1 || f_empty !== 1'b1) begin bad++; $display("FAIL fwft_edge_k fill=%0d empty=%b want fill=1 empty=1", f_fill, f_empty); end
        @(posedge clk); #1;
        total++; if (f_empty !== 1'b0 || f_dv !== 1'b1) begin bad++; $display("FAIL fwft_edge_k1 empty=%b dv=%b want empty=0 dv=1", f_empty, f_dv); end
        total++; if (f_dout !== 16'hA5A5) begin bad++; $display("FAIL fwft_data got=%h want=a5a5", f_dout); end
        f_rd = 1;
        @(posedge clk); #1 f_rd = 0;
        total++; if (f_empty !== 1'b1 || f_fill !== 4'd0 || f_unf !== 1'b0) begin bad++; $display("FAIL fwft_pop empty=%b fill=%0d unf=%b want 1/0/0", f_empty, f_fill, f_unf); end
        f_rd = 1;
        @(posedge clk); #1 f_rd = 0;
        total++; if (f_unf !== 1'b1) begin bad++; $display("FAIL fwft_underflow got=%b want=1", f_unf); end
        for (int i = 0; i < 3; i++) begin
            f_wr = 1; f_din = 16'h0011 * 16'(i + 1); sb_f.push_back(f_din);
            @(posedge clk); #1;
        end
        f_wr = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            total++; if (f_empty !== 1'b0 || f_dout !== sb_f[0]) begin bad++; $display("FAIL fwft_b2b%0d got=%h empty=%b want=%h", i, f_dout, f_empty, sb_f[0]); end
            void'(sb_f.pop_front());
            f_rd = 1;
            @(posedge clk); #1;
        end
        f_rd = 0;
        total++; if (f_empty !== 1'b1 || f_fill !== 4'd0) begin bad++; $display("FAIL fwft_b2b_end empty=%b fill=%0d want 1/0", f_empty, f_fill); end
    endtask

    task automatic test_clr_reset;
        for (int i = 0; i < 5; i++) drive_s(1, 16'h0300 + 16'(i), 0, 0);
        total++; if (s_fill !== 4'd5) begin bad++; $display("FAIL clr_prefill got=%0d want=5", s_fill); end
        drive_s(1, 16'h1234, 0, 1);
        total++; if (s_fill !== 4'd0 || s_empty !== 1'b1 || s_ovf !== 1'b0 || s_ae !== 1'b1) begin
            bad++; $display("FAIL clr_state fill=%0d empty=%b ovf=%b ae=%b want 0/1/0/1", s_fill, s_empty, s_ovf, s_ae);
        end
        total++; if (s_dout !== m_last) begin bad++; $display("FAIL clr_dout_hold got=%h want=%h", s_dout, m_last); end
        drive_s(0, 16'h0000, 1, 0);
        total++; if (s_unf !== 1'b1 || s_dv !== 1'b0) begin bad++; $display("FAIL clr_read_empty unf=%b dv=%b want 1/0", s_unf, s_dv); end
        drive_s(1, 16'h0042, 0, 0);
        drive_s(0, 16'h0000, 1, 0);
        if (s_dv === 1'b1 && sb_s.size() != 0) begin
            exp_w = sb_s.pop_front();
            total++; if (s_dout !== exp_w) begin bad++; $display("FAIL clr_next_data got=%h want=%h", s_dout, exp_w); end
        end else begin
            total++; bad++; $display("FAIL clr_next_dv got=%b want=1", s_dv);
        end
        rst = 1;
        @(posedge clk); #1 rst = 0;
        total++; if (s_dout !== 16'h0000) begin bad++; $display("FAIL final_reset_dout got=%h want=0000", s_dout); end
        total++; if ({s_fill, s_empty, s_ae, s_full, s_af, s_dv, s_ovf, s_unf} !== {4'd0, 7'b1100000}) begin
            bad++; $display("FAIL final_reset_flags got=%b want=%b", {s_fill, s_empty, s_ae, s_full, s_af, s_dv, s_ovf, s_unf}, {4'd0, 7'b1100000});
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_steady_wrap();
        test_full_rdwr();
        test_fwft();
        test_clr_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
